// File: rtl/starflux_pkg.sv
// Shared Starflux constants and the flat grid indexing helper.
package starflux_pkg;

  localparam int unsigned ROW_PLAYER       = 0;
  localparam int unsigned TICK_DIV_DEFAULT = 2500000;
  localparam int unsigned COOLDOWN_DEFAULT = 4;

  // Flat bit position of cell (r, c) in a row-major grid of the given width.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running game tick divider; tick_c is high while the count sits on its last value.
module tick_divider
  import starflux_pkg::*;
#(
  parameter int unsigned DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned CNTW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(DIV - 1);

  logic [CNTW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNTW'(1);
    end
  end

  assign tick_c = (count == LAST);

endmodule

// File: rtl/bullet_field.sv
// Bullet plane: player bullets rise, enemy bullets fall on each game tick;
// head-on pairs annihilate and edge exits are reported for the hit logic.
module bullet_field
  import starflux_pkg::*;
#(
  parameter int unsigned COLS     = 8,
  parameter int unsigned ROWS     = 16,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned COOLDOWN = COOLDOWN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    player_fire,
  input  logic [$clog2(COLS)-1:0] player_col,
  input  logic                    enemy_fire,
  input  logic [$clog2(COLS)-1:0] enemy_col,
  output logic                    player_ack,
  output logic                    enemy_ack,
  output logic [ROWS*COLS-1:0]    up_grid,
  output logic [ROWS*COLS-1:0]    down_grid,
  output logic [COLS-1:0]         top_exit,
  output logic [COLS-1:0]         bottom_exit,
  output logic                    clash,
  output logic                    tick
);

  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned SLOTS = 1 << CW;
  localparam int unsigned CDW   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int unsigned TOP   = ROWS - 1;
  // Column codes that name a real column; out-of-range requests are dropped.
  localparam logic [SLOTS-1:0] COL_OK = {SLOTS{1'b1}} >> (SLOTS - COLS);

  logic            tick_c;
  logic            p_pend, e_pend;
  logic [CW-1:0]   p_col, e_col;
  logic [CDW-1:0]  p_cool, e_cool;
  logic            p_take, e_take;
  logic [COLS-1:0] spawn_up, spawn_dn;
  logic [CELLS-1:0] up_sh, dn_sh, x_up, x_dn, co, up_nx, dn_nx;

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_c (tick_c)
  );

  assign p_take = player_fire & ~p_pend & (p_cool == '0) & COL_OK[player_col];
  assign e_take = enemy_fire  & ~e_pend & (e_cool == '0) & COL_OK[enemy_col];

  assign spawn_up = p_pend ? (COLS'(1) << p_col) : '0;
  assign spawn_dn = e_pend ? (COLS'(1) << e_col) : '0;

  // x_up/x_dn mark, in post-shift coordinates, bullets that would swap cells.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == ROW_PLAYER) begin : g_bottom
      assign up_sh[idx(r, 0, COLS) +: COLS] = spawn_up;
      assign x_up[idx(r, 0, COLS) +: COLS]  = '0;
    end else begin : g_rise
      assign up_sh[idx(r, 0, COLS) +: COLS] = up_grid[idx(r - 1, 0, COLS) +: COLS];
      assign x_up[idx(r, 0, COLS) +: COLS]  = up_grid[idx(r - 1, 0, COLS) +: COLS]
                                            & down_grid[idx(r, 0, COLS) +: COLS];
    end

    if (r == TOP) begin : g_top
      assign dn_sh[idx(r, 0, COLS) +: COLS] = spawn_dn;
      assign x_dn[idx(r, 0, COLS) +: COLS]  = '0;
    end else begin : g_fall
      assign dn_sh[idx(r, 0, COLS) +: COLS] = down_grid[idx(r + 1, 0, COLS) +: COLS];
      assign x_dn[idx(r, 0, COLS) +: COLS]  = down_grid[idx(r + 1, 0, COLS) +: COLS]
                                            & up_grid[idx(r, 0, COLS) +: COLS];
    end
  end

  assign co    = up_sh & dn_sh;
  assign up_nx = up_sh & ~(x_up | co);
  assign dn_nx = dn_sh & ~(x_dn | co);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick        <= 1'b0;
      player_ack  <= 1'b0;
      enemy_ack   <= 1'b0;
      up_grid     <= '0;
      down_grid   <= '0;
      top_exit    <= '0;
      bottom_exit <= '0;
      clash       <= 1'b0;
      p_pend      <= 1'b0;
      e_pend      <= 1'b0;
      p_col       <= '0;
      e_col       <= '0;
      p_cool      <= '0;
      e_cool      <= '0;
    end else begin
      tick        <= tick_c;
      player_ack  <= 1'b0;
      enemy_ack   <= 1'b0;
      top_exit    <= '0;
      bottom_exit <= '0;
      clash       <= 1'b0;
      if (tick_c) begin
        up_grid     <= up_nx;
        down_grid   <= dn_nx;
        top_exit    <= up_grid[idx(TOP, 0, COLS) +: COLS];
        bottom_exit <= down_grid[idx(ROW_PLAYER, 0, COLS) +: COLS];
        clash       <= (|x_up) | (|co);

        if (p_pend) begin
          p_pend <= 1'b0;
          p_cool <= CDW'(COOLDOWN);
        end else if (p_cool != '0) begin
          p_cool <= p_cool - CDW'(1);
        end

        if (e_pend) begin
          e_pend <= 1'b0;
          e_cool <= CDW'(COOLDOWN);
        end else if (e_cool != '0) begin
          e_cool <= e_cool - CDW'(1);
        end
      end else begin
        // Requests are only taken between ticks so a spawn never races the shift.
        if (p_take) begin
          p_pend     <= 1'b1;
          p_col      <= player_col;
          player_ack <= 1'b1;
        end
        if (e_take) begin
          e_pend    <= 1'b1;
          e_col     <= enemy_col;
          enemy_ack <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bullet_field.sv
// Directed bench for bullet_field with a cycle-level reference model feeding a scoreboard.
module tb_bullet_field;

  localparam int COLS     = 5;
  localparam int ROWS     = 4;
  localparam int TICK_DIV = 4;
  localparam int COOLDOWN = 2;
  localparam int CW       = $clog2(COLS);
  localparam int N        = ROWS * COLS;

  logic          clk;
  logic          reset;
  logic          player_fire, enemy_fire;
  logic [CW-1:0] player_col, enemy_col;
  logic          player_ack, enemy_ack;
  logic [N-1:0]  up_grid, down_grid;
  logic [COLS-1:0] top_exit, bottom_exit;
  logic          clash, tick;

  bullet_field #(
    .COLS(COLS), .ROWS(ROWS), .TICK_DIV(TICK_DIV), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .reset(reset),
    .player_fire(player_fire), .player_col(player_col),
    .enemy_fire(enemy_fire), .enemy_col(enemy_col),
    .player_ack(player_ack), .enemy_ack(enemy_ack),
    .up_grid(up_grid), .down_grid(down_grid),
    .top_exit(top_exit), .bottom_exit(bottom_exit),
    .clash(clash), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            tick;
    logic            pack;
    logic            eack;
    logic            clash;
    logic [N-1:0]    up;
    logic [N-1:0]    dn;
    logic [COLS-1:0] te;
    logic [COLS-1:0] be;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   pack_cnt = 0;

  // Reference model state
  int mcnt = 0;
  bit m_up [ROWS][COLS];
  bit m_dn [ROWS][COLS];
  bit m_pp = 0, m_pe = 0;
  int m_cp = 0, m_ce = 0, m_kp = 0, m_ke = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    exp_t e;
    bit nu [ROWS][COLS];
    bit nd [ROWS][COLS];
    bit tk, kill;
    e = '0;
    if (reset) begin
      mcnt = 0;
      m_up = '{default: 0};
      m_dn = '{default: 0};
      m_pp = 0; m_pe = 0; m_cp = 0; m_ce = 0; m_kp = 0; m_ke = 0;
    end else begin
      tk = (mcnt == TICK_DIV - 1);
      mcnt = tk ? 0 : mcnt + 1;
      e.tick = tk;
      if (tk) begin
        nu = '{default: 0};
        nd = '{default: 0};
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (m_up[r][c]) begin
              if (r == ROWS - 1) e.te[c] = 1'b1;
              else begin
                kill = m_dn[r+1][c] || ((r + 2 < ROWS) ? m_dn[r+2][c] : (m_pe && m_ce == c));
                if (kill) e.clash = 1'b1; else nu[r+1][c] = 1;
              end
            end
            if (m_dn[r][c]) begin
              if (r == 0) e.be[c] = 1'b1;
              else begin
                kill = m_up[r-1][c] || ((r >= 2) ? m_up[r-2][c] : (m_pp && m_cp == c));
                if (kill) e.clash = 1'b1; else nd[r-1][c] = 1;
              end
            end
          end
        end
        if (m_pp) begin
          if (m_dn[1][m_cp]) e.clash = 1'b1; else nu[0][m_cp] = 1;
          m_pp = 0; m_kp = COOLDOWN;
        end else if (m_kp > 0) m_kp--;
        if (m_pe) begin
          if (m_up[ROWS-2][m_ce]) e.clash = 1'b1; else nd[ROWS-1][m_ce] = 1;
          m_pe = 0; m_ke = COOLDOWN;
        end else if (m_ke > 0) m_ke--;
        m_up = nu;
        m_dn = nd;
      end else begin
        if (player_fire && !m_pp && m_kp == 0 && int'(player_col) < COLS) begin
          m_pp = 1; m_cp = int'(player_col); e.pack = 1'b1;
        end
        if (enemy_fire && !m_pe && m_ke == 0 && int'(enemy_col) < COLS) begin
          m_pe = 1; m_ce = int'(enemy_col); e.eack = 1'b1;
        end
      end
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        e.up[r*COLS+c] = m_up[r][c];
        e.dn[r*COLS+c] = m_dn[r][c];
      end
    q.push_back(e);
  endtask

  // One clock: push the model's prediction, then pop and compare after the edge.
  task automatic cyc();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (player_ack === 1'b1) pack_cnt++;
    check("sb_queue_nonempty", 64'(q.size() > 0), 64'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sb_tick", tick, e.tick);
      check("sb_player_ack", player_ack, e.pack);
      check("sb_enemy_ack", enemy_ack, e.eack);
      check("sb_up_grid", up_grid, e.up);
      check("sb_down_grid", down_grid, e.dn);
      check("sb_top_exit", top_exit, e.te);
      check("sb_bottom_exit", bottom_exit, e.be);
      check("sb_clash", clash, e.clash);
    end
  endtask

  task automatic next_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 2 * TICK_DIV);
    check("tick_wait", tick, 1'b1);
  endtask

  int sp[$];
  int n;

  initial begin
    reset = 1'b1;
    player_fire = 1'b0; enemy_fire = 1'b0;
    player_col = '0; enemy_col = '0;
    cyc(); cyc();
    check("reset_up", up_grid, 0);
    check("reset_tick", tick, 0);
    reset = 1'b0;

    // Single shot, column 2: ack, travel, top exit
    player_fire = 1'b1; player_col = CW'(2);
    cyc();
    player_fire = 1'b0;
    check("shot_ack", player_ack, 1'b1);
    next_tick();
    check("shot_row0", up_grid, 64'h4);
    next_tick(); next_tick(); next_tick();
    check("shot_row3", up_grid, 64'h20000);
    next_tick();
    check("shot_exit", top_exit, 5'b00100);
    check("shot_empty", up_grid, 0);

    // Held fire with cooldown: spawns three ticks apart, one ack each
    pack_cnt = 0;
    player_fire = 1'b1; player_col = CW'(0);
    for (int t = 1; t <= 7; t++) begin
      next_tick();
      if (up_grid[COLS-1:0] != '0) sp.push_back(t);
    end
    player_fire = 1'b0;
    check("hold_spawns", sp.size(), 3);
    if (sp.size() == 3) begin
      check("hold_gap1", sp[1] - sp[0], 3);
      check("hold_gap2", sp[2] - sp[0], 6);
    end
    check("hold_acks", pack_cnt, 3);
    for (int t = 0; t < 5; t++) next_tick();
    check("hold_drained", up_grid, 0);

    // Head-on crossing: up row1 col0 against down row2 col0
    player_fire = 1'b1; player_col = CW'(0);
    enemy_fire = 1'b1; enemy_col = CW'(0);
    cyc();
    player_fire = 1'b0; enemy_fire = 1'b0;
    next_tick(); next_tick();
    check("cross_up_pre", up_grid, 64'h20);
    check("cross_dn_pre", down_grid, 64'h400);
    next_tick();
    check("cross_up", up_grid, 0);
    check("cross_dn", down_grid, 0);
    check("cross_clash", clash, 1'b1);
    check("cross_top_exit", top_exit, 0);
    check("cross_bot_exit", bottom_exit, 0);

    // Co-location: up row0 col1 and down row2 col1 both land in row 1
    enemy_fire = 1'b1; enemy_col = CW'(1);
    cyc();
    enemy_fire = 1'b0;
    next_tick();
    player_fire = 1'b1; player_col = CW'(1);
    cyc();
    player_fire = 1'b0;
    next_tick();
    check("coloc_up_pre", up_grid, 64'h2);
    check("coloc_dn_pre", down_grid, 64'h800);
    next_tick();
    check("coloc_up", up_grid, 0);
    check("coloc_dn", down_grid, 0);
    check("coloc_clash", clash, 1'b1);

    // Out-of-range column and a request on the tick cycle are dropped
    next_tick(); next_tick();
    player_fire = 1'b1; player_col = CW'(5);
    cyc();
    check("badcol5_ack", player_ack, 1'b0);
    player_col = CW'(7);
    cyc();
    check("badcol7_ack", player_ack, 1'b0);
    player_fire = 1'b0;
    next_tick();
    check("badcol_grid", up_grid, 0);
    while (mcnt != TICK_DIV - 1) cyc();
    enemy_fire = 1'b1; enemy_col = CW'(3);
    cyc();
    enemy_fire = 1'b0;
    check("tickreq_ack0", enemy_ack, 1'b0);
    cyc();
    check("tickreq_ack1", enemy_ack, 1'b0);
    next_tick();
    check("tickreq_grid", down_grid, 0);

    // Reset with three bullets in flight and a pending enemy shot
    player_fire = 1'b1; player_col = CW'(0);
    enemy_fire = 1'b1; enemy_col = CW'(4);
    cyc();
    player_fire = 1'b0; enemy_fire = 1'b0;
    next_tick(); next_tick(); next_tick();
    player_fire = 1'b1; player_col = CW'(2);
    cyc();
    player_fire = 1'b0;
    next_tick();
    check("flight_up", up_grid, 64'h8004);
    check("flight_dn", down_grid, 64'h10);
    enemy_fire = 1'b1; enemy_col = CW'(1);
    cyc();
    enemy_fire = 1'b0;
    check("flight_pending_ack", enemy_ack, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_up", up_grid, 0);
    check("rst_dn", down_grid, 0);
    check("rst_acks", {player_ack, enemy_ack}, 0);
    check("rst_exits", {top_exit, bottom_exit}, 0);
    check("rst_clash_tick", {clash, tick}, 0);
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 3 * TICK_DIV);
    check("rst_tick_latency", n, TICK_DIV);
    check("rst_no_spawn_up", up_grid, 0);
    check("rst_no_spawn_dn", down_grid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
